oursring_req_ppln_mstage: RTL and testbench

// - Parametrised successor of the single-stage ring request pipeline: N registered stages on each of the AW, W and AR channels.
// - Every stage is a 2-entry skid buffer, so all valid, ready and data paths are registered and full throughput is kept.
// - Sits between a ring-stop request master and the ring, wherever long wires need STAGES cycles of retiming.
// - Adds an idle indication; channels stay fully independent (no AW/W coupling, no reordering).

---
 rtl/pygmy_intf_typedef.sv | 52 +++++
 rtl/oursring_skid_buf.sv | 77 +++++++
 rtl/oursring_req_ppln_mstage.sv | 176 +++++++++++++++++
 tb/tb_oursring_req_ppln_mstage.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pygmy_intf_typedef.sv
// Shared ring-interface typedefs.
// Purpose: request-channel payload structs for the ring request interface,
//          the skid-buffer stage state encoding, the pipeline depth ceiling
//          and a helper for saturating performance counters.
// Ports:   none (package).
package pygmy_intf_typedef;

  typedef struct packed {
    logic [7:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
  } oursring_req_if_aw_t;

  typedef struct packed {
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
  } oursring_req_if_w_t;

  typedef struct packed {
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
  } oursring_req_if_ar_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } oursring_skid_st_e;

  localparam int OURSRING_PPLN_MAX_STAGES = 8;

  // Clear has priority; otherwise count a stall cycle but stop at all-ones.
  function automatic logic [31:0] perf_next(input logic [31:0] cnt,
                                            input logic        clr,
                                            input logic        stall);
    logic [31:0] nxt;
    nxt = cnt;
    if (clr) begin
      nxt = '0;
    end else if (stall && (cnt != 32'hFFFF_FFFF)) begin
      nxt = cnt + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/oursring_skid_buf.sv
// One registered pipeline stage: a 2-entry skid buffer.
// Purpose: cuts valid, ready and data paths with flops while sustaining one
//          beat per cycle. The second entry absorbs the beat that arrives in
//          the cycle the downstream side stalls, because upstream ready is
//          only ever a decode of the local state register.
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   s_data/s_valid/s_ready upstream (sink) side
//   d_data/d_valid/d_ready downstream (source) side
//   empty                  stage holds no beat
module oursring_skid_buf
  import pygmy_intf_typedef::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] d_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic             empty
);

  oursring_skid_st_e state;
  logic [WIDTH-1:0]  main_q;
  logic [WIDTH-1:0]  skid_q;
  logic              push;
  logic              pop;

  assign s_ready = (state != TWO);
  assign d_valid = (state != EMPTY);
  assign d_data  = main_q;
  assign empty   = (state == EMPTY);
  assign push    = s_valid & s_ready;
  assign pop     = d_valid & d_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) state <= ONE;
        ONE: begin
          if (push && !pop) begin
            state <= TWO;
          end else if (pop && !push) begin
            state <= EMPTY;
          end
        end
        TWO:     if (pop) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

  // Payload registers carry no reset: valid is what qualifies them.
  // In ONE with push&pop the new beat replaces the departing one directly,
  // so there is no bubble; a push without pop parks in the skid entry.
  always_ff @(posedge clk) begin
    case (state)
      EMPTY: if (push) main_q <= s_data;
      ONE: begin
        if (push && pop) begin
          main_q <= s_data;
        end else if (push) begin
          skid_q <= s_data;
        end
      end
      TWO:     if (pop) main_q <= skid_q;
      default: ;
    endcase
  end

endmodule

// File: rtl/oursring_req_ppln_mstage.sv
// Multi-stage ring request pipeline.
// Purpose: STAGES registered skid-buffer stages on each of the AW, W and AR
//          channels between a ring-stop request master and the ring. The
//          channels are independent; order within a channel is preserved.
//          STAGES = 0 is a pure wire-through. Valid range 0..8
//          (OURSRING_PPLN_MAX_STAGES).
// Ports:
//   clk, rstn                            clock, async active-low reset
//   i_req_if_{aw,w,ar}{,valid,ready}     upstream channels (ready is output)
//   o_req_if_{aw,w,ar}{,valid,ready}     downstream channels (ready is input)
//   o_idle                               registered: every stage empty
//   i_perf_clr, o_perf_stall_{aw,w,ar}   only with OURSRING_REQ_PPLN_PERF_EN:
//                                        synchronous clear and 32-bit
//                                        saturating downstream stall counters
// Configuration macro: OURSRING_REQ_PPLN_PERF_EN
module oursring_req_ppln_mstage
  import pygmy_intf_typedef::*;
#(
  parameter int STAGES = 1,
  parameter int AW_W   = $bits(oursring_req_if_aw_t),
  parameter int W_W    = $bits(oursring_req_if_w_t),
  parameter int AR_W   = $bits(oursring_req_if_ar_t)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW_W-1:0] i_req_if_aw,
  input  logic            i_req_if_awvalid,
  output logic            i_req_if_awready,
  input  logic [W_W-1:0]  i_req_if_w,
  input  logic            i_req_if_wvalid,
  output logic            i_req_if_wready,
  input  logic [AR_W-1:0] i_req_if_ar,
  input  logic            i_req_if_arvalid,
  output logic            i_req_if_arready,
  output logic [AW_W-1:0] o_req_if_aw,
  output logic            o_req_if_awvalid,
  input  logic            o_req_if_awready,
  output logic [W_W-1:0]  o_req_if_w,
  output logic            o_req_if_wvalid,
  input  logic            o_req_if_wready,
  output logic [AR_W-1:0] o_req_if_ar,
  output logic            o_req_if_arvalid,
  input  logic            o_req_if_arready,
  output logic            o_idle
`ifdef OURSRING_REQ_PPLN_PERF_EN
  ,
  input  logic            i_perf_clr,
  output logic [31:0]     o_perf_stall_aw,
  output logic [31:0]     o_perf_stall_w,
  output logic [31:0]     o_perf_stall_ar
`endif
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_req_if_aw      = i_req_if_aw;
      assign o_req_if_awvalid = i_req_if_awvalid;
      assign i_req_if_awready = o_req_if_awready;
      assign o_req_if_w       = i_req_if_w;
      assign o_req_if_wvalid  = i_req_if_wvalid;
      assign i_req_if_wready  = o_req_if_wready;
      assign o_req_if_ar      = i_req_if_ar;
      assign o_req_if_arvalid = i_req_if_arvalid;
      assign i_req_if_arready = o_req_if_arready;
      assign o_idle           = 1'b1;
    end else begin : g_pipe
      // Index k is the link feeding stage k; index STAGES is the output.
      logic [AW_W-1:0]   aw_data [STAGES+1];
      logic [STAGES:0]   aw_valid;
      logic [STAGES:0]   aw_ready;
      logic [STAGES-1:0] aw_empty;
      logic [W_W-1:0]    w_data [STAGES+1];
      logic [STAGES:0]   w_valid;
      logic [STAGES:0]   w_ready;
      logic [STAGES-1:0] w_empty;
      logic [AR_W-1:0]   ar_data [STAGES+1];
      logic [STAGES:0]   ar_valid;
      logic [STAGES:0]   ar_ready;
      logic [STAGES-1:0] ar_empty;
      logic              idle_q;

      assign aw_data[0]         = i_req_if_aw;
      assign aw_valid[0]        = i_req_if_awvalid;
      assign i_req_if_awready   = aw_ready[0];
      assign o_req_if_aw        = aw_data[STAGES];
      assign o_req_if_awvalid   = aw_valid[STAGES];
      assign aw_ready[STAGES]   = o_req_if_awready;

      assign w_data[0]          = i_req_if_w;
      assign w_valid[0]         = i_req_if_wvalid;
      assign i_req_if_wready    = w_ready[0];
      assign o_req_if_w         = w_data[STAGES];
      assign o_req_if_wvalid    = w_valid[STAGES];
      assign w_ready[STAGES]    = o_req_if_wready;

      assign ar_data[0]         = i_req_if_ar;
      assign ar_valid[0]        = i_req_if_arvalid;
      assign i_req_if_arready   = ar_ready[0];
      assign o_req_if_ar        = ar_data[STAGES];
      assign o_req_if_arvalid   = ar_valid[STAGES];
      assign ar_ready[STAGES]   = o_req_if_arready;

      for (genvar g = 0; g < STAGES; g++) begin : g_stage
        oursring_skid_buf #(.WIDTH(AW_W)) u_aw (
          .clk     (clk),
          .rstn    (rstn),
          .s_data  (aw_data[g]),
          .s_valid (aw_valid[g]),
          .s_ready (aw_ready[g]),
          .d_data  (aw_data[g+1]),
          .d_valid (aw_valid[g+1]),
          .d_ready (aw_ready[g+1]),
          .empty   (aw_empty[g])
        );
        oursring_skid_buf #(.WIDTH(W_W)) u_w (
          .clk     (clk),
          .rstn    (rstn),
          .s_data  (w_data[g]),
          .s_valid (w_valid[g]),
          .s_ready (w_ready[g]),
          .d_data  (w_data[g+1]),
          .d_valid (w_valid[g+1]),
          .d_ready (w_ready[g+1]),
          .empty   (w_empty[g])
        );
        oursring_skid_buf #(.WIDTH(AR_W)) u_ar (
          .clk     (clk),
          .rstn    (rstn),
          .s_data  (ar_data[g]),
          .s_valid (ar_valid[g]),
          .s_ready (ar_ready[g]),
          .d_data  (ar_data[g+1]),
          .d_valid (ar_valid[g+1]),
          .d_ready (ar_ready[g+1]),
          .empty   (ar_empty[g])
        );
      end

      // Registered so o_idle never carries a combinational path through the
      // stage decode; it trails the stage states by one cycle.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          idle_q <= 1'b1;
        end else begin
          idle_q <= (&aw_empty) & (&w_empty) & (&ar_empty);
        end
      end

      assign o_idle = idle_q;
    end
  endgenerate

`ifdef OURSRING_REQ_PPLN_PERF_EN
  logic [31:0] stall_aw_q;
  logic [31:0] stall_w_q;
  logic [31:0] stall_ar_q;

  // A stall cycle is one where the ring side withholds ready from a beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_aw_q <= '0;
      stall_w_q  <= '0;
      stall_ar_q <= '0;
    end else begin
      stall_aw_q <= perf_next(stall_aw_q, i_perf_clr, o_req_if_awvalid && !o_req_if_awready);
      stall_w_q  <= perf_next(stall_w_q,  i_perf_clr, o_req_if_wvalid  && !o_req_if_wready);
      stall_ar_q <= perf_next(stall_ar_q, i_perf_clr, o_req_if_arvalid && !o_req_if_arready);
    end
  end

  assign o_perf_stall_aw = stall_aw_q;
  assign o_perf_stall_w  = stall_w_q;
  assign o_perf_stall_ar = stall_ar_q;
`endif

endmodule

// File: tb/tb_oursring_req_ppln_mstage.sv
// Bench for oursring_req_ppln_mstage: a STAGES=2 instance checked against a
// per-channel FIFO scoreboard, plus a STAGES=0 instance sharing its inputs.
module tb_oursring_req_ppln_mstage;
  import pygmy_intf_typedef::*;

  localparam int STAGES = 2;
  localparam int AW_W   = $bits(oursring_req_if_aw_t);
  localparam int W_W    = $bits(oursring_req_if_w_t);
  localparam int AR_W   = $bits(oursring_req_if_ar_t);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic [127:0] upData [3];
  logic [2:0]   upValid;
  logic [2:0]   upFire;
  logic [2:0]   dnReady;
  logic [2:0]   upReady;
  logic [2:0]   dnValid;
  logic [127:0] dnData [3];
  logic [2:0]   prevStall;
  logic [127:0] prevData [3];

  logic [AW_W-1:0] i_req_if_aw;
  logic [W_W-1:0]  i_req_if_w;
  logic [AR_W-1:0] i_req_if_ar;
  logic            i_req_if_awready, i_req_if_wready, i_req_if_arready;
  logic [AW_W-1:0] o_req_if_aw;
  logic [W_W-1:0]  o_req_if_w;
  logic [AR_W-1:0] o_req_if_ar;
  logic            o_req_if_awvalid, o_req_if_wvalid, o_req_if_arvalid;
  logic            o_idle;

  logic            zAwReady, zWReady, zArReady;
  logic [AW_W-1:0] zAw;
  logic [W_W-1:0]  zW;
  logic [AR_W-1:0] zAr;
  logic            zAwValid, zWValid, zArValid, zIdle;

`ifdef OURSRING_REQ_PPLN_PERF_EN
  logic        i_perf_clr;
  logic [31:0] o_perf_stall_aw, o_perf_stall_w, o_perf_stall_ar;
  logic [31:0] zPerfAw, zPerfW, zPerfAr;
`endif

  assign i_req_if_aw = upData[0][AW_W-1:0];
  assign i_req_if_w  = upData[1][W_W-1:0];
  assign i_req_if_ar = upData[2][AR_W-1:0];
  assign upReady     = {i_req_if_arready, i_req_if_wready, i_req_if_awready};
  assign dnValid     = {o_req_if_arvalid, o_req_if_wvalid, o_req_if_awvalid};
  assign dnData[0]   = 128'(o_req_if_aw);
  assign dnData[1]   = 128'(o_req_if_w);
  assign dnData[2]   = 128'(o_req_if_ar);

  oursring_req_ppln_mstage #(.STAGES(STAGES)) dut (
    .clk(clk), .rstn(rstn),
    .i_req_if_aw(i_req_if_aw), .i_req_if_awvalid(upValid[0]), .i_req_if_awready(i_req_if_awready),
    .i_req_if_w(i_req_if_w),   .i_req_if_wvalid(upValid[1]),  .i_req_if_wready(i_req_if_wready),
    .i_req_if_ar(i_req_if_ar), .i_req_if_arvalid(upValid[2]), .i_req_if_arready(i_req_if_arready),
    .o_req_if_aw(o_req_if_aw), .o_req_if_awvalid(o_req_if_awvalid), .o_req_if_awready(dnReady[0]),
    .o_req_if_w(o_req_if_w),   .o_req_if_wvalid(o_req_if_wvalid),   .o_req_if_wready(dnReady[1]),
    .o_req_if_ar(o_req_if_ar), .o_req_if_arvalid(o_req_if_arvalid), .o_req_if_arready(dnReady[2]),
    .o_idle(o_idle)
`ifdef OURSRING_REQ_PPLN_PERF_EN
    , .i_perf_clr(i_perf_clr), .o_perf_stall_aw(o_perf_stall_aw),
    .o_perf_stall_w(o_perf_stall_w), .o_perf_stall_ar(o_perf_stall_ar)
`endif
  );

  oursring_req_ppln_mstage #(.STAGES(0)) dut0 (
    .clk(clk), .rstn(rstn),
    .i_req_if_aw(i_req_if_aw), .i_req_if_awvalid(upValid[0]), .i_req_if_awready(zAwReady),
    .i_req_if_w(i_req_if_w),   .i_req_if_wvalid(upValid[1]),  .i_req_if_wready(zWReady),
    .i_req_if_ar(i_req_if_ar), .i_req_if_arvalid(upValid[2]), .i_req_if_arready(zArReady),
    .o_req_if_aw(zAw), .o_req_if_awvalid(zAwValid), .o_req_if_awready(dnReady[0]),
    .o_req_if_w(zW),   .o_req_if_wvalid(zWValid),   .o_req_if_wready(dnReady[1]),
    .o_req_if_ar(zAr), .o_req_if_arvalid(zArValid), .o_req_if_arready(dnReady[2]),
    .o_idle(zIdle)
`ifdef OURSRING_REQ_PPLN_PERF_EN
    , .i_perf_clr(i_perf_clr), .o_perf_stall_aw(zPerfAw),
    .o_perf_stall_w(zPerfW), .o_perf_stall_ar(zPerfAr)
`endif
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [127:0] qAw [$];
  logic [127:0] qW  [$];
  logic [127:0] qAr [$];

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [127:0] chMask(input int ch);
    int w;
    w = (ch == 0) ? AW_W : ((ch == 1) ? W_W : AR_W);
    return (128'(1) << w) - 128'(1);
  endfunction

  function automatic int sbSize(input int ch);
    return (ch == 0) ? qAw.size() : ((ch == 1) ? qW.size() : qAr.size());
  endfunction

  task automatic sbPush(input int ch, input logic [127:0] d);
    if (ch == 0) qAw.push_back(d);
    else if (ch == 1) qW.push_back(d);
    else qAr.push_back(d);
  endtask

  task automatic sbPop(input int ch, output logic [127:0] d);
    if (ch == 0) d = qAw.pop_front();
    else if (ch == 1) d = qW.pop_front();
    else d = qAr.pop_front();
  endtask

  // Observe one cycle at the falling edge: record the transfers that the
  // next rising edge will perform and compare delivered beats to the model.
  task automatic scoreCycle();
    logic [127:0] expData;
    @(negedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      if (prevStall[ch]) begin
        checkOutput("stall_valid", 128'(dnValid[ch]), 128'(1));
        checkOutput("stall_data", dnData[ch], prevData[ch]);
      end
      upFire[ch] = upValid[ch] && upReady[ch];
      if (upFire[ch]) sbPush(ch, upData[ch]);
      if (dnValid[ch] && dnReady[ch]) begin
        checkOutput("beat_expected", 128'(sbSize(ch) > 0), 128'(1));
        if (sbSize(ch) > 0) begin
          sbPop(ch, expData);
          checkOutput("beat_order", dnData[ch], expData);
        end
      end
      checkOutput("capacity", 128'(sbSize(ch) <= 2 * STAGES), 128'(1));
      prevStall[ch] = dnValid[ch] && !dnReady[ch];
      prevData[ch]  = dnData[ch];
    end
    checkOutput("bypass_ar", 128'(zAr), 128'(i_req_if_ar));
    checkOutput("bypass_arready", 128'(zArReady), 128'(dnReady[2]));
    checkOutput("bypass_arvalid", 128'(zArValid), 128'(upValid[2]));
  endtask

  // Chances are out of 4. A master only changes valid/data once its beat
  // has been taken (or when it was not offering one).
  task automatic applyStimulus(input int validChance, input int readyChance);
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      if (!upValid[ch] || upFire[ch]) begin
        upValid[ch] = (int'($urandom_range(0, 3)) < validChance);
        upData[ch]  = {$urandom(), $urandom(), $urandom(), $urandom()} & chMask(ch);
      end
      upFire[ch]  = 1'b0;
      dnReady[ch] = (int'($urandom_range(0, 3)) < readyChance);
    end
  endtask

  initial begin
    int  acc;
    bit  fire;
    bit  drained;
    int  waitCnt;

    rstn      = 1'b0;
    upValid   = '0;
    upFire    = '0;
    dnReady   = '0;
    prevStall = '0;
    for (int ch = 0; ch < 3; ch++) begin
      upData[ch]   = '0;
      prevData[ch] = '0;
    end
`ifdef OURSRING_REQ_PPLN_PERF_EN
    i_perf_clr = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_dnvalid", 128'(dnValid), 128'(0));
    checkOutput("rst_upready", 128'(upReady), 128'(3'b111));
    checkOutput("rst_idle", 128'(o_idle), 128'(1));
    checkOutput("bypass_idle", 128'(zIdle), 128'(1));
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Latency and streaming on AW: beats 0x10, 0x11, ...
    $display("[TB] AW latency/streaming");
    dnReady    = 3'b111;
    upValid[0] = 1'b1;
    upData[0]  = 128'h10;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      upData[0] = 128'(16 + n);
      @(negedge clk);
      checkOutput("lat_valid", 128'(dnValid[0]), 128'(n >= STAGES));
      if (n >= STAGES) checkOutput("lat_data", dnData[0], 128'(16 + n - STAGES));
      checkOutput("lat_idle", 128'(o_idle), 128'(n < 2));
      checkOutput("lat_upready", 128'(upReady[0]), 128'(1));
    end
    @(posedge clk);
    #1;
    upValid[0] = 1'b0;
    repeat (STAGES + 3) @(posedge clk);
    @(negedge clk);
    checkOutput("lat_drained", 128'(dnValid[0]), 128'(0));
    checkOutput("lat_idle_end", 128'(o_idle), 128'(1));
    @(posedge clk);
    #1;

    // Fill W with downstream stalled, then drain
    $display("[TB] W fill/drain");
    dnReady[1] = 1'b0;
    upValid[1] = 1'b1;
    upData[1]  = 128'h20;
    acc        = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      fire = upReady[1];
      @(posedge clk);
      #1;
      if (fire) begin
        acc++;
        upData[1] = 128'(32 + acc);
      end
    end
    @(negedge clk);
    checkOutput("fill_count", 128'(acc), 128'(2 * STAGES));
    checkOutput("fill_upready", 128'(upReady[1]), 128'(0));
    dnReady[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("drain_valid", 128'(dnValid[1]), 128'(1));
      checkOutput("drain_data", dnData[1], 128'(32 + i));
      fire = upReady[1];
      @(posedge clk);
      #1;
      if (fire) begin
        acc++;
        upData[1] = 128'(32 + acc);
      end
      @(negedge clk);
    end
    waitCnt = 0;
    while (!upReady[1] && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("drain_ready_timeout", 128'(upReady[1]), 128'(1));
    @(posedge clk);
    #1;
    upValid[1] = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_empty", 128'(dnValid[1]), 128'(0));
    checkOutput("drain_idle", 128'(o_idle), 128'(1));
    @(posedge clk);
    #1;

    // Random traffic on all channels
    $display("[TB] random traffic");
    prevStall = '0;
    upFire    = '0;
    for (int i = 0; i < 4500; i++) begin
      scoreCycle();
      applyStimulus(3, (i < 2000) ? 3 : 2);
    end
    drained = 1'b0;
    for (int i = 0; i < 60 && !drained; i++) begin
      scoreCycle();
      applyStimulus(0, 4);
      drained = ((sbSize(0) + sbSize(1) + sbSize(2)) == 0) && (upValid == 3'b000);
    end
    checkOutput("random_drained", 128'(drained), 128'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("random_idle", 128'(o_idle), 128'(1));
    checkOutput("random_novalid", 128'(dnValid), 128'(0));
    @(posedge clk);
    #1;

    // Reset with beats in flight
    $display("[TB] reset mid-transfer");
    prevStall = '0;
    upFire    = '0;
    dnReady   = '0;
    for (int ch = 0; ch < 3; ch++) begin
      upValid[ch] = 1'b1;
      upData[ch]  = {$urandom(), $urandom(), $urandom(), $urandom()} & chMask(ch);
    end
    repeat (3) begin
      scoreCycle();
      applyStimulus(4, 0);
    end
    checkOutput("preload_valid", 128'(dnValid), 128'(3'b111));
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_valid", 128'(dnValid), 128'(0));
    checkOutput("async_rst_ready", 128'(upReady), 128'(3'b111));
    upValid = '0;
    upFire  = '0;
    prevStall = '0;
    qAw.delete();
    qW.delete();
    qAr.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      dnReady = 3'b111;
      @(negedge clk);
      checkOutput("no_stale_beat", 128'(dnValid), 128'(0));
      checkOutput("post_rst_idle", 128'(o_idle), 128'(1));
    end

`ifdef OURSRING_REQ_PPLN_PERF_EN
    // AR stalled five cycles, then clear
    $display("[TB] perf counters");
    @(posedge clk);
    #1;
    i_perf_clr = 1'b1;
    dnReady    = 3'b000;
    @(posedge clk);
    #1;
    i_perf_clr = 1'b0;
    upValid[2] = 1'b1;
    upData[2]  = 128'h55;
    @(posedge clk);
    #1;
    upValid[2] = 1'b0;
    waitCnt = 0;
    @(negedge clk);
    while (!dnValid[2] && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("perf_arvalid", 128'(dnValid[2]), 128'(1));
    checkOutput("perf_ar_start", 128'(o_perf_stall_ar), 128'(0));
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("perf_ar_5", 128'(o_perf_stall_ar), 128'(5));
    checkOutput("perf_aw_0", 128'(o_perf_stall_aw), 128'(0));
    dnReady = 3'b111;
    @(posedge clk);
    #1;
    i_perf_clr = 1'b1;
    @(posedge clk);
    #1;
    i_perf_clr = 1'b0;
    @(negedge clk);
    checkOutput("perf_ar_clr", 128'(o_perf_stall_ar), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
